// File: rtl/c_ext_defs.sv
// Shared definitions for the compressed-instruction align/expand slice:
// RVC quadrant and funct3 codes, base opcodes, FSM state and interface structs.
package c_ext_defs;

    localparam int          C_XLEN      = 32;
    localparam logic [31:0] C_INSTR_NOP = 32'h0000_0013;

    localparam logic [1:0] OPC_C0  = 2'b00;
    localparam logic [1:0] OPC_C1  = 2'b01;
    localparam logic [1:0] OPC_C2  = 2'b10;
    localparam logic [1:0] OPC_32B = 2'b11;

    localparam logic [2:0] F3_C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] F3_C0_LW       = 3'b010;
    localparam logic [2:0] F3_C0_SW       = 3'b110;
    localparam logic [2:0] F3_C1_ADDI     = 3'b000;
    localparam logic [2:0] F3_C1_JAL      = 3'b001;
    localparam logic [2:0] F3_C1_LI       = 3'b010;
    localparam logic [2:0] F3_C1_LUI      = 3'b011;
    localparam logic [2:0] F3_C1_MISC     = 3'b100;
    localparam logic [2:0] F3_C1_J        = 3'b101;
    localparam logic [2:0] F3_C1_BEQZ     = 3'b110;
    localparam logic [2:0] F3_C1_BNEZ     = 3'b111;
    localparam logic [2:0] F3_C2_SLLI     = 3'b000;
    localparam logic [2:0] F3_C2_LWSP     = 3'b010;
    localparam logic [2:0] F3_C2_MISC     = 3'b100;
    localparam logic [2:0] F3_C2_SWSP     = 3'b110;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef enum logic {ALIGNED, STRADDLE} type_calign_state_e;

    typedef struct packed {
        logic [31:0]       instr;
        logic              is_comp;
        logic [C_XLEN-1:0] pc_aligned;
        logic              stall;
        logic              icache_req;
        logic              icache_req_kill;
        logic              icache_flush;
    } type_cext2if_s;

    typedef struct packed {
        logic [31:0] instr_un;
    } type_if2cext_s;

endpackage

// File: rtl/c_expander.sv
// Combinational RV32C expander: maps a 16-bit compressed encoding to its
// 32-bit equivalent and flags reserved or RV32-illegal encodings.
module c_expander
    import c_ext_defs::*;
(
    input  logic [15:0] instr_c,
    output logic [31:0] instr_exp,
    output logic        illegal
);

    logic [2:0] funct3;
    logic [4:0] rd_full;
    logic [4:0] rs2_full;
    logic [4:0] rd_p;
    logic [4:0] rs1_p;
    logic [6:0] alu_f7;
    logic [2:0] alu_f3;

    assign funct3   = instr_c[15:13];
    assign rd_full  = instr_c[11:7];
    assign rs2_full = instr_c[6:2];
    assign rd_p     = {2'b01, instr_c[4:2]};
    assign rs1_p    = {2'b01, instr_c[9:7]};

    always_comb begin
        instr_exp = {16'h0000, instr_c};
        illegal   = 1'b0;
        alu_f7    = (instr_c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000;
        case (instr_c[6:5])
            2'b00:   alu_f3 = 3'b000;
            2'b01:   alu_f3 = 3'b100;
            2'b10:   alu_f3 = 3'b110;
            default: alu_f3 = 3'b111;
        endcase
        case (instr_c[1:0])
            OPC_C0: begin
                case (funct3)
                    F3_C0_ADDI4SPN: begin
                        instr_exp = {2'b00, instr_c[10:7], instr_c[12:11], instr_c[5], instr_c[6], 2'b00,
                                     5'd2, 3'b000, rd_p, OP_IMM};
                        illegal   = (instr_c[12:5] == 8'h00);
                    end
                    F3_C0_LW: instr_exp = {5'b00000, instr_c[5], instr_c[12:10], instr_c[6], 2'b00,
                                           rs1_p, 3'b010, rd_p, OP_LOAD};
                    F3_C0_SW: instr_exp = {5'b00000, instr_c[5], instr_c[12], rd_p, rs1_p, 3'b010,
                                           instr_c[11:10], instr_c[6], 2'b00, OP_STORE};
                    default:  illegal = 1'b1;
                endcase
            end
            OPC_C1: begin
                case (funct3)
                    F3_C1_ADDI: instr_exp = {{6{instr_c[12]}}, instr_c[12], instr_c[6:2], rd_full, 3'b000, rd_full, OP_IMM};
                    F3_C1_JAL, F3_C1_J: instr_exp = {instr_c[12], instr_c[8], instr_c[10:9], instr_c[6], instr_c[7],
                                                     instr_c[2], instr_c[11], instr_c[5:3], instr_c[12], {8{instr_c[12]}},
                                                     (funct3 == F3_C1_JAL) ? 5'd1 : 5'd0, OP_JAL};
                    F3_C1_LI: instr_exp = {{6{instr_c[12]}}, instr_c[12], instr_c[6:2], 5'd0, 3'b000, rd_full, OP_IMM};
                    F3_C1_LUI: begin
                        // rd == x2 reuses this slot for ADDI16SP
                        if (rd_full == 5'd2)
                            instr_exp = {{3{instr_c[12]}}, instr_c[4:3], instr_c[5], instr_c[2], instr_c[6], 4'b0000,
                                         5'd2, 3'b000, 5'd2, OP_IMM};
                        else
                            instr_exp = {{15{instr_c[12]}}, instr_c[6:2], rd_full, OP_LUI};
                        illegal = ({instr_c[12], instr_c[6:2]} == 6'd0);
                    end
                    F3_C1_MISC: begin
                        case (instr_c[11:10])
                            2'b00: begin
                                instr_exp = {7'b0000000, instr_c[6:2], rs1_p, 3'b101, rs1_p, OP_IMM};
                                illegal   = instr_c[12];
                            end
                            2'b01: begin
                                instr_exp = {7'b0100000, instr_c[6:2], rs1_p, 3'b101, rs1_p, OP_IMM};
                                illegal   = instr_c[12];
                            end
                            2'b10: instr_exp = {{6{instr_c[12]}}, instr_c[12], instr_c[6:2], rs1_p, 3'b111, rs1_p, OP_IMM};
                            default: begin
                                instr_exp = {alu_f7, rd_p, rs1_p, alu_f3, rs1_p, OP_REG};
                                illegal   = instr_c[12];
                            end
                        endcase
                    end
                    F3_C1_BEQZ, F3_C1_BNEZ: instr_exp = {instr_c[12], {3{instr_c[12]}}, instr_c[6:5], instr_c[2], 5'd0,
                                                         rs1_p, {2'b00, funct3[0]}, instr_c[11:10], instr_c[4:3],
                                                         instr_c[12], OP_BRANCH};
                    default: illegal = 1'b1;
                endcase
            end
            OPC_C2: begin
                case (funct3)
                    F3_C2_SLLI: begin
                        instr_exp = {7'b0000000, instr_c[6:2], rd_full, 3'b001, rd_full, OP_IMM};
                        illegal   = instr_c[12];
                    end
                    F3_C2_LWSP: begin
                        instr_exp = {4'b0000, instr_c[3:2], instr_c[12], instr_c[6:4], 2'b00, 5'd2, 3'b010, rd_full, OP_LOAD};
                        illegal   = (rd_full == 5'd0);
                    end
                    F3_C2_MISC: begin
                        if (rs2_full != 5'd0)
                            instr_exp = {7'b0000000, rs2_full, instr_c[12] ? rd_full : 5'd0, 3'b000, rd_full, OP_REG};
                        else if (!instr_c[12]) begin
                            instr_exp = {12'h000, rd_full, 3'b000, 5'd0, OP_JALR};
                            illegal   = (rd_full == 5'd0);
                        end else if (rd_full == 5'd0)
                            instr_exp = 32'h0010_0073;
                        else
                            instr_exp = {12'h000, rd_full, 3'b000, 5'd1, OP_JALR};
                    end
                    F3_C2_SWSP: instr_exp = {4'b0000, instr_c[8:7], instr_c[12], rs2_full, 5'd2, 3'b010,
                                             instr_c[11:9], 2'b00, OP_STORE};
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/c_align_unit.sv
// Fetch-side aligner: picks the halfword at pc_i, expands RVC encodings and
// stitches 32-bit instructions that straddle two fetch words.
module c_align_unit
    import c_ext_defs::*;
#(
    parameter int          XLEN      = C_XLEN,
    parameter logic [31:0] INSTR_NOP = C_INSTR_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_un_i,
    input  logic            icache_ack_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic            flush_i,
    output logic [31:0]     instr_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] pc_aligned_o,
    output logic            is_comp_o,
    output logic            illegal_o,
    output logic            stall_o,
    output logic            icache_req_o,
    output logic            icache_req_kill_o,
    output logic            icache_flush_o
);

    type_calign_state_e state;
    logic [15:0]        hbuf;
    logic [XLEN-1:0]    hbuf_pc;
    type_if2cext_s      if2cext;
    type_cext2if_s      cext2if;
    logic [15:0]        half;
    logic               half_comp;
    logic               kill;
    logic               straddle_start;
    logic [31:0]        exp_instr;
    logic               exp_illegal;
    logic               valid;
    logic               illegal;
    logic [XLEN-1:0]    instr_pc;

    assign if2cext.instr_un = instr_un_i;
    assign half             = pc_i[1] ? if2cext.instr_un[31:16] : if2cext.instr_un[15:0];
    assign half_comp        = (half[1:0] != OPC_32B);
    assign kill             = redirect_i | flush_i;
    assign straddle_start   = (state == ALIGNED) && icache_ack_i && pc_i[1] && !half_comp;

    c_expander u_expander (
        .instr_c   (half),
        .instr_exp (exp_instr),
        .illegal   (exp_illegal)
    );

    always_comb begin
        cext2if            = '0;
        cext2if.instr      = INSTR_NOP;
        cext2if.pc_aligned = pc_i;
        cext2if.icache_req = (state == STRADDLE);
        instr_pc           = pc_i;
        valid              = 1'b0;
        illegal            = 1'b0;
        if (kill) begin
            cext2if.icache_req_kill = redirect_i;
            cext2if.icache_flush    = flush_i;
        end else if (!icache_ack_i) begin
            // Hold the fetch PC while waiting for the word; stay quiet during reset
            cext2if.stall = rst_n;
            if (state == STRADDLE) begin
                cext2if.pc_aligned = hbuf_pc;
                instr_pc           = hbuf_pc;
            end
        end else if (state == STRADDLE) begin
            cext2if.instr      = {if2cext.instr_un[15:0], hbuf};
            cext2if.pc_aligned = hbuf_pc;
            instr_pc           = hbuf_pc;
            valid              = 1'b1;
        end else if (half_comp) begin
            cext2if.instr   = exp_illegal ? {16'h0000, half} : exp_instr;
            cext2if.is_comp = 1'b1;
            valid           = 1'b1;
            illegal         = exp_illegal;
        end else if (!pc_i[1]) begin
            cext2if.instr = if2cext.instr_un;
            valid         = 1'b1;
        end else begin
            // Upper half starts a 32-bit instruction: advance fetch by 2 to the next word
            cext2if.is_comp = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ALIGNED;
            hbuf    <= '0;
            hbuf_pc <= '0;
        end else if (kill) begin
            state   <= ALIGNED;
            hbuf    <= '0;
            hbuf_pc <= '0;
        end else if (!stall_i && icache_ack_i) begin
            if (state == STRADDLE) begin
                state <= ALIGNED;
            end else if (straddle_start) begin
                state   <= STRADDLE;
                hbuf    <= half;
                hbuf_pc <= pc_i;
            end
        end
    end

    assign instr_o           = cext2if.instr;
    assign instr_valid_o     = valid;
    assign instr_pc_o        = instr_pc;
    assign pc_aligned_o      = cext2if.pc_aligned;
    assign is_comp_o         = cext2if.is_comp;
    assign illegal_o         = illegal;
    assign stall_o           = cext2if.stall;
    assign icache_req_o      = cext2if.icache_req;
    assign icache_req_kill_o = cext2if.icache_req_kill;
    assign icache_flush_o    = cext2if.icache_flush;

endmodule

// File: tb/tb_c_align_unit.sv
// Randomized self-checking bench for c_align_unit: RVC instructions are built
// field-by-field from the ISA layout and checked against a pending-fragment model.
module tb_c_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] instr_un_i;
    logic        icache_ack_i;
    logic        stall_i;
    logic        redirect_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_aligned_o;
    logic        is_comp_o;
    logic        illegal_o;
    logic        stall_o;
    logic        icache_req_o;
    logic        icache_req_kill_o;
    logic        icache_flush_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] half;
        logic [31:0] pc;
    } frag_t;

    frag_t pending[$];

    always #5 clk = ~clk;

    c_align_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_i              (pc_i),
        .instr_un_i        (instr_un_i),
        .icache_ack_i      (icache_ack_i),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .flush_i           (flush_i),
        .instr_o           (instr_o),
        .instr_valid_o     (instr_valid_o),
        .instr_pc_o        (instr_pc_o),
        .pc_aligned_o      (pc_aligned_o),
        .is_comp_o         (is_comp_o),
        .illegal_o         (illegal_o),
        .stall_o           (stall_o),
        .icache_req_o      (icache_req_o),
        .icache_req_kill_o (icache_req_kill_o),
        .icache_flush_o    (icache_flush_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // Builds a random legal RVC instruction together with its architectural 32-bit form
    task automatic genCompressed(output logic [15:0] c, output logic [31:0] e);
        int          kind = $urandom_range(0, 9);
        logic [4:0]  rd   = 5'($urandom_range(1, 31));
        logic [4:0]  rs2  = 5'($urandom_range(1, 31));
        logic [2:0]  rp   = 3'($urandom);
        logic [2:0]  rq   = 3'($urandom);
        logic        f    = 1'($urandom);
        logic [31:0] imm;
        case (kind)
            0: begin
                imm = $urandom_range(0, 63) - 32;
                c = {3'b000, imm[5], rd, imm[4:0], 2'b01};
                e = enc_i(imm, rd, 3'd0, rd, 7'h13);
            end
            1: begin
                imm = $urandom_range(0, 63) - 32;
                c = {3'b010, imm[5], rd, imm[4:0], 2'b01};
                e = enc_i(imm, 5'd0, 3'd0, rd, 7'h13);
            end
            2: begin
                imm = 4 * $urandom_range(0, 31);
                c = {3'b010, imm[5:3], rp, imm[2], imm[6], rq, 2'b00};
                e = enc_i(imm, {2'b01, rp}, 3'd2, {2'b01, rq}, 7'h03);
            end
            3: begin
                imm = 4 * $urandom_range(0, 31);
                c = {3'b110, imm[5:3], rp, imm[2], imm[6], rq, 2'b00};
                e = enc_s(imm, {2'b01, rq}, {2'b01, rp}, 3'd2, 7'h23);
            end
            4: begin
                c = {4'b1000, rd, rs2, 2'b10};
                e = enc_r(7'd0, rs2, 5'd0, 3'd0, rd, 7'h33);
            end
            5: begin
                c = {4'b1001, rd, rs2, 2'b10};
                e = enc_r(7'd0, rs2, rd, 3'd0, rd, 7'h33);
            end
            6: begin
                imm = 2 * $urandom_range(0, 2047) - 2048;
                c = {3'b101, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
                e = enc_j(imm, 5'd0);
            end
            7: begin
                imm = 2 * $urandom_range(0, 255) - 256;
                c = {2'b11, f, imm[8], imm[4:3], rp, imm[7:6], imm[2:1], imm[5], 2'b01};
                e = enc_b(imm, 5'd0, {2'b01, rp}, {2'b00, f}, 7'h63);
            end
            8: begin
                imm = $urandom_range(0, 31);
                c = {3'b000, 1'b0, rd, imm[4:0], 2'b10};
                e = enc_i(imm, rd, 3'd1, rd, 7'h13);
            end
            default: begin
                imm = 4 * $urandom_range(0, 63);
                c = {3'b010, imm[5], rd, imm[4:2], imm[7:6], 2'b10};
                e = enc_i(imm, 5'd2, 3'd2, rd, 7'h03);
            end
        endcase
    endtask

    task automatic checkResetOutputs(input logic [31:0] pc);
        checkOutput("rst_instr", instr_o, 32'h0000_0013);
        checkOutput("rst_valid", instr_valid_o, 0);
        checkOutput("rst_comp", is_comp_o, 0);
        checkOutput("rst_illegal", illegal_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_req", icache_req_o, 0);
        checkOutput("rst_kill", icache_req_kill_o, 0);
        checkOutput("rst_flush", icache_flush_o, 0);
        checkOutput("rst_pc_aligned", pc_aligned_o, pc);
        checkOutput("rst_instr_pc", instr_pc_o, pc);
    endtask

    // One fetch cycle: drive, compare against the model, then advance the model past the clock edge
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] word, input logic ack,
                                 input logic stall, input logic redir, input logic flush,
                                 input logic [31:0] comp_exp, input logic comp_ill);
        logic [15:0] h = pc[1] ? word[31:16] : word[15:0];
        logic [31:0] e_instr = 32'h0000_0013;
        logic [31:0] e_pc = pc;
        logic        e_valid = 0, e_comp = 0, e_stall = 0, e_ill = 0;
        pc_i = pc; instr_un_i = word; icache_ack_i = ack;
        stall_i = stall; redirect_i = redir; flush_i = flush;
        #2;
        if (redir || flush) begin
        end else if (!ack) begin
            e_stall = 1;
        end else if (pending.size() > 0) begin
            e_instr = {word[15:0], pending[0].half};
            e_pc = pending[0].pc;
            e_valid = 1;
        end else if (h[1:0] != 2'b11) begin
            e_instr = comp_ill ? {16'h0000, h} : comp_exp;
            e_comp = 1; e_valid = 1; e_ill = comp_ill;
        end else if (!pc[1]) begin
            e_instr = word;
            e_valid = 1;
        end else begin
            e_comp = 1;
        end
        checkOutput("valid", instr_valid_o, e_valid);
        checkOutput("req_kill", icache_req_kill_o, redir);
        checkOutput("flush", icache_flush_o, flush);
        checkOutput("req", icache_req_o, pending.size() > 0);
        if (!(redir || flush)) begin
            checkOutput("stall", stall_o, e_stall);
            checkOutput("is_comp", is_comp_o, e_comp);
            checkOutput("illegal", illegal_o, e_ill);
            checkOutput("instr", instr_o, e_instr);
            if (ack) begin
                checkOutput("pc_aligned", pc_aligned_o, e_pc);
                checkOutput("instr_pc", instr_pc_o, e_pc);
            end
        end
        @(posedge clk);
        #1;
        if (redir || flush) pending.delete();
        else if (!stall && ack) begin
            if (pending.size() > 0) void'(pending.pop_front());
            else if (pc[1] && h[1:0] == 2'b11) pending.push_back('{h, pc});
        end
    endtask

    initial begin
        logic [15:0] cand;
        logic [31:0] cexp;
        logic [31:0] pc;
        logic [31:0] word;
        logic        ill;
        rst_n = 0; pc_i = 32'h100; instr_un_i = 0; icache_ack_i = 0;
        stall_i = 0; redirect_i = 0; flush_i = 0;
        #2;
        checkResetOutputs(32'h100);
        @(posedge clk); #1;
        rst_n = 1;

        applyStimulus(32'h0, 32'h00A0_0093, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 32'hDEAD_4505, 1, 0, 0, 0, 32'h0010_0513, 0);
        applyStimulus(32'h2, 32'h4505_1234, 1, 0, 0, 0, 32'h0010_0513, 0);
        applyStimulus(32'h0, 32'h1234_0000, 1, 0, 0, 0, 0, 1);
        applyStimulus(32'h0, 32'h0000_0000, 0, 0, 0, 0, 0, 0);

        applyStimulus(32'h2, 32'h0093_0001, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h4, $urandom, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h4, 32'hBEEF_00A0, 1, 1, 0, 0, 0, 0);
        applyStimulus(32'h4, 32'hBEEF_00A0, 1, 0, 0, 0, 0, 0);

        applyStimulus(32'h2, 32'h0093_0001, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h4, 32'h0000_00A0, 1, 0, 1, 0, 0, 0);
        applyStimulus(32'h4, 32'h00A0_0093, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h2, 32'h0093_0001, 1, 0, 0, 1, 0, 0);
        applyStimulus(32'h2, 32'h0093_0001, 1, 1, 0, 0, 0, 0);
        applyStimulus(32'h4, 32'h00A0_0093, 1, 0, 0, 0, 0, 0);

        applyStimulus(32'hFFFF_FFFE, 32'h0093_0001, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 32'h0000_00A0, 1, 0, 0, 0, 0, 0);

        applyStimulus(32'h2, 32'h0093_0001, 1, 0, 0, 0, 0, 0);
        icache_ack_i = 0; pc_i = 32'h4;
        #1 rst_n = 0;
        #1 checkResetOutputs(32'h4);
        pending.delete();
        @(posedge clk); #1;
        rst_n = 1;
        applyStimulus(32'h4, 32'h00A0_0093, 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            pc = $urandom & 32'hFFFF_FFFE;
            ill = 0; cexp = 0;
            if ($urandom_range(0, 19) == 0) begin
                cand = 16'h0000; ill = 1;
            end else if ($urandom_range(0, 1) == 0) begin
                genCompressed(cand, cexp);
            end else begin
                cand = {14'($urandom), 2'b11};
            end
            word = $urandom;
            if (pc[1]) word[31:16] = cand;
            else       word[15:0]  = cand;
            applyStimulus(pc, word, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, cexp, ill);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_align_unit.md
Name: c_align_unit

Overview:
- Sits between the I-cache response path and the fetch stage. Receives the raw 32-bit word-aligned fetch word and the current fetch PC.
- Extracts the instruction at a halfword-aligned PC and expands RVC encodings to 32-bit. Stitches 32-bit instructions that straddle a word boundary.
- Returns the issue PC (pc_aligned), the size flag (is_comp) and the instruction to fetch. Fetch computes next PC = pc_aligned + (is_comp ? 2 : 4).

Parameters:
- XLEN, 32, address/data width.
- INSTR_NOP, 32'h0000_0013, bubble instruction.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- pc_i  input  XLEN  current fetch PC (pc_ff); halfword aligned
- instr_un_i  input  32  raw word from I-cache for address {pc_i[XLEN-1:2],2'b00}
- icache_ack_i  input  1  instr_un_i valid this cycle
- stall_i  input  1  downstream/forward stall; hold all state
- redirect_i  input  1  CSR/EXE/WFI new-PC request
- flush_i  input  1  fence.i I-cache flush request
- instr_o  output  32  expanded/whole instruction to ID
- instr_valid_o  output  1  instr_o is a real instruction (0 = bubble)
- instr_pc_o  output  XLEN  true PC of instr_o
- pc_aligned_o  output  XLEN  base PC for fetch next-PC computation
- is_comp_o  output  1  select increment of 2
- illegal_o  output  1  compressed encoding illegal
- stall_o  output  1  hold fetch PC
- icache_req_o  output  1  extra I-cache request strobe
- icache_req_kill_o  output  1  kill in-flight I-cache request
- icache_flush_o  output  1  I-cache flush

Behaviour:
- State register: ALIGNED, STRADDLE. Buffer: hbuf[15:0], hbuf_pc[XLEN-1:0].
- Async reset: state ALIGNED, hbuf 0, hbuf_pc 0.
- All outputs are combinational from state, buffer and inputs.
- With state ALIGNED after reset and icache_ack_i=0, outputs are:
  - instr_o=INSTR_NOP, instr_valid_o=0, is_comp_o=0, illegal_o=0, stall_o=0
  - icache_req_o=0, icache_req_kill_o=0, icache_flush_o=0
  - pc_aligned_o=pc_i, instr_pc_o=pc_i
- half = pc_i[1] ? instr_un_i[31:16] : instr_un_i[15:0]. A half is compressed when half[1:0] != 2'b11.
- ALIGNED, ack=1, half compressed:
  - instr_o = expand(half), is_comp_o=1, pc_aligned_o=pc_i, instr_pc_o=pc_i, instr_valid_o=1.
  - illegal_o is set from the expander. When illegal, instr_o = {16'h0,half}.
- ALIGNED, ack=1, pc_i[1]=0, 32-bit instruction: instr_o=instr_un_i, is_comp_o=0, valid=1.
- ALIGNED, ack=1, pc_i[1]=1, 32-bit instruction (straddle):
  - Outputs: instr_valid_o=0, instr_o=INSTR_NOP, is_comp_o=1, pc_aligned_o=pc_i. Fetch therefore advances to the next word.
  - Captures hbuf=half and hbuf_pc=pc_i.
  - Transitions to STRADDLE when ~stall_i.
- STRADDLE, ack=1:
  - instr_o={instr_un_i[15:0],hbuf}, instr_valid_o=1, is_comp_o=0.
  - pc_aligned_o=hbuf_pc, instr_pc_o=hbuf_pc. Fetch next PC = hbuf_pc+4.
  - Transitions to ALIGNED when ~stall_i.
- Either state, ack=0: instr_valid_o=0 and stall_o=1. State and buffer hold.
- stall_i=1: no state or buffer update; outputs are still driven.
- redirect_i or flush_i has priority over everything:
  - Next state ALIGNED; hbuf invalidated.
  - icache_req_kill_o=1 with redirect_i; icache_flush_o=1 with flush_i.
  - instr_valid_o=0 in that cycle.
- Simultaneous redirect_i and straddle capture: the redirect wins and no capture occurs.
- Reset mid-STRADDLE returns to ALIGNED immediately.
- icache_req_o=1 in STRADDLE, so the second word is fetched even when the base request is gated.
- Widths: PC arithmetic is modulo 2^XLEN. A straddle at 0xFFFF_FFFE wraps to word 0.

Decomposition:
- Shared package c_ext_defs:
  - RVC opcode quadrant constants and funct3 encodings.
  - State enum type_calign_state_e.
  - Structs type_cext2if_s (instr, is_comp, pc_aligned, stall, icache_req, icache_req_kill, icache_flush) and type_if2cext_s (instr_un).
- Sub-module c_expander: purely combinational 16→32 RVC expansion with an illegal flag; instantiated once.

Test Plan:
- pc_i=0x0, instr_un_i=0x00A00093, ack=1 -> instr_o=0x00A00093, is_comp_o=0, pc_aligned_o=0x0, valid=1.
- pc_i=0x0, instr_un_i[15:0]=0x4505 -> instr_o=0x00100513, is_comp_o=1, instr_pc_o=0x0.
- pc_i=0x2, instr_un_i=0x4505_xxxx -> instr_o=0x00100513, is_comp_o=1, pc_aligned_o=0x2.
- Straddle:
  - pc_i=0x2, instr_un_i=0x0093_0001 -> valid=0, is_comp_o=1, state STRADDLE.
  - Next pc_i=0x4, instr_un_i=0xxxxx_00A0 -> instr_o=0x00A00093, instr_pc_o=0x2, pc_aligned_o=0x2, is_comp_o=0.
  - During the same sequence, ack=0 for 3 cycles while in STRADDLE -> stall_o=1, hbuf stays 0x0093, result unchanged once ack=1.
- redirect_i=1 while in STRADDLE -> next state ALIGNED, icache_req_kill_o=1, valid=0. Following word at pc_i=0x4 is decoded fresh.
- pc_i=0x0, instr_un_i[15:0]=0x0000 -> illegal_o=1, instr_o=0x00000000, is_comp_o=1. Also assert rst_n=0 mid-STRADDLE -> ALIGNED with reset outputs.
